// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds uart_tx one byte at a time: pop, pulse send, wait for done.
// Producer may push on consecutive cycles; pushes while full are dropped and flagged.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          uart_tx_send,
    output logic [7:0]    uart_tx_data,
    input  logic          uart_tx_done,
    input  logic          uart_tx_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = (AW+1)'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    state_t        state;
    state_t        state_nxt;
    logic          push_ok;
    logic          pop;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // No bypass: a push against a full FIFO is rejected even if a pop happens.
    assign push_ok = wr_en && !full;

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (uart_tx_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory contents are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            uart_tx_send <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            overflow     <= wr_en && full;
            uart_tx_send <= pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                uart_tx_data <= mem[rd_ptr];
            end
            case ({push_ok, pop})
                2'b10:   level <= level + ONE_L;
                2'b01:   level <= level - ONE_L;
                default: level <= level;
            endcase
        end
    end

endmodule
